// File: rtl/regbus_host_pkg.sv
// Shared types and constants for the host-link to register-bus bridge.
package regbus_host_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [7:0] OPC_WR  = 8'h57;  // 'W'
  localparam logic [7:0] OPC_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  typedef enum logic [3:0] {
    StIdle,
    StAddrH,
    StAddrL,
    StBe,
    StData,
    StWrIssue,
    StRdIssue,
    StRdWait,
    StResp
  } state_e;

endpackage

// File: rtl/regbus_resp_ser.sv
// Response serializer: holds up to four bytes and hands them to the host TX
// one at a time, most significant byte first, over a valid/ready handshake.
module regbus_resp_ser
  import regbus_host_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] ld_data_i,  // bytes leave from [31:24] downward
  input  logic [2:0]        ld_len_i,   // 1 or 4
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              done_o      // last byte accepted this cycle
);

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              accept;

  // Head of the shift register is always the byte on offer, so tx_data
  // cannot move while a byte is stalled.
  assign tx_valid_o = (cnt_q != 3'd0);
  assign tx_data_o  = sh_q[DATA_W-1 -: 8];
  assign accept     = tx_valid_o & tx_ready_i;
  assign done_o     = accept & (cnt_q == 3'd1);

  // Next-state: load a new response or shift out on each accepted byte.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = ld_data_i;
      cnt_d = ld_len_i;
    end else if (accept) begin
      sh_d  = {sh_q[DATA_W-9:0], 8'h00};
      cnt_d = cnt_q - 3'd1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= 3'd0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regbus_host_bridge.sv
// Host byte-stream to register-bus bridge. Parses 'W'/'R' packets from the
// UART RX strobe, issues a single write or read on the register slave and
// returns an ack, read data or error byte to the host TX.
module regbus_host_bridge
  import regbus_host_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 100000,
  parameter int unsigned RD_WAIT_MAX  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wr_en,
  output logic [BE_W-1:0]   be,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wdata,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rd_rdy,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int unsigned ToW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned RwW = $clog2(RD_WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [RwW-1:0]    rw_cnt_q, rw_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              parsing;
  logic              timeout;
  logic              err_evt;
  logic              ser_load;
  logic [DATA_W-1:0] ser_data;
  logic [2:0]        ser_len;
  logic              ser_done;

  assign parsing = (state_q == StAddrH) || (state_q == StAddrL) ||
                   (state_q == StBe)    || (state_q == StData);

  // Strobes and bus fields come straight from state and registers, so a
  // reset mid-packet can never leave a partial strobe behind.
  assign wr_en   = (state_q == StWrIssue);
  assign rd_en   = (state_q == StRdIssue);
  assign wr_addr = addr_q;
  assign rd_addr = addr_q;
  assign be      = be_q;
  assign wdata   = wdata_q;
  assign busy    = (state_q != StIdle);
  assign err_cnt = err_cnt_q;

  // Next-state, packet parsing, timeouts and error accounting.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    dcnt_d   = dcnt_q;
    to_cnt_d = to_cnt_q;
    rw_cnt_d = rw_cnt_q;
    timeout  = 1'b0;
    err_evt  = 1'b0;
    ser_load = 1'b0;
    ser_data = '0;
    ser_len  = 3'd0;

    // Inter-byte silence counter, restarted by every received byte.
    if (parsing) begin
      if (rx_valid) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == ToW'(IDLE_TIMEOUT - 1)) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
    end

    // Bytes arriving while a transaction is in flight are dropped.
    if (rx_valid && !parsing && (state_q != StIdle)) begin
      err_evt = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if ((rx_data == OPC_WR) || (rx_data == OPC_RD)) begin
            is_wr_d  = (rx_data == OPC_WR);
            to_cnt_d = '0;
            state_d  = StAddrH;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      StAddrH: begin
        if (rx_valid) begin
          addr_d  = {addr_q[7:0], rx_data};
          state_d = StAddrL;
        end
      end
      StAddrL: begin
        if (rx_valid) begin
          addr_d  = {addr_q[7:0], rx_data};
          state_d = is_wr_q ? StBe : StRdIssue;
        end
      end
      StBe: begin
        if (rx_valid) begin
          be_d    = rx_data[BE_W-1:0];
          dcnt_d  = 2'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (rx_valid) begin
          wdata_d = {wdata_q[DATA_W-9:0], rx_data};
          dcnt_d  = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            state_d = StWrIssue;
          end
        end
      end
      StWrIssue: begin
        ser_load = 1'b1;
        ser_data = {RSP_ACK, 24'h000000};
        ser_len  = 3'd1;
        state_d  = StResp;
      end
      StRdIssue: begin
        rw_cnt_d = '0;
        state_d  = StRdWait;
      end
      StRdWait: begin
        if (rd_rdy) begin
          ser_load = 1'b1;
          ser_data = rdata;
          ser_len  = 3'd4;
          state_d  = StResp;
        end else if (rw_cnt_q == RwW'(RD_WAIT_MAX - 1)) begin
          ser_load = 1'b1;
          ser_data = {RSP_ERR, 24'h000000};
          ser_len  = 3'd1;
          err_evt  = 1'b1;
          state_d  = StResp;
        end else begin
          rw_cnt_d = rw_cnt_q + RwW'(1);
        end
      end
      StResp: begin
        if (ser_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      err_evt  = 1'b1;
      to_cnt_d = '0;
      state_d  = StIdle;
    end

    // Any number of error causes in one cycle count as a single error.
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      dcnt_q    <= 2'd0;
      to_cnt_q  <= '0;
      rw_cnt_q  <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      dcnt_q    <= dcnt_d;
      to_cnt_q  <= to_cnt_d;
      rw_cnt_q  <= rw_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  regbus_resp_ser u_resp_ser (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ser_load),
    .ld_data_i  (ser_data),
    .ld_len_i   (ser_len),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .done_o     (ser_done)
  );

endmodule
